seq_calculator: RTL

SEQ_CALCULATOR -- requirements
Module: seq_calculator

---
 rtl/seq_calculator_if.sv | 28 ++
 rtl/seq_calculator.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_calculator_if.sv
// Request/result handshake bundle for seq_calculator.
// master drives requests and out_ready; slave is the calculator.
interface seq_calculator_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] D;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             ovf;
  logic             div0;

  modport master (
    output in_valid, opcode, A, B, C, D, out_ready,
    input  in_ready, out_valid, out, ovf, div0
  );

  modport slave (
    input  in_valid, opcode, A, B, C, D, out_ready,
    output in_ready, out_valid, out, ovf, div0
  );
endinterface

// File: rtl/seq_calculator.sv
// Multi-cycle calculator: single-cycle ALU ops plus iterative
// shift-add multiply and restoring divide, with held results.
module seq_calculator #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input logic        clk,
  input logic        reset,
  seq_calculator_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, EXEC, ITER, HOLD
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_ADD4 = 3'd4;
  localparam logic [2:0] OP_SUB4 = 3'd5;
  localparam logic [2:0] OP_REM  = 3'd6;
  localparam logic [2:0] OP_ROR  = 3'd7;

  localparam logic [WIDTH-1:0] W_L =
    WIDTH'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, c_q, d_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] out_q;
  logic             ovf_q, div0_q, ov_q;

  logic [WIDTH:0]   sum2;
  logic [WIDTH+1:0] sum4, sbc;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] ex_res;
  logic             ex_ovf, ex_dz;

  logic [WIDTH:0]   ms, dt;
  logic [WIDTH-1:0] dsub;
  logic             dge;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic [WIDTH-1:0] it_res;
  logic             it_ovf;
  logic             go_iter;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = ov_q;
  assign bus.out       = out_q;
  assign bus.ovf       = ovf_q;
  assign bus.div0      = div0_q;

  always_comb begin
    sum2 = {1'b0, a_q} + {1'b0, b_q};
    sum4 = {2'b0, a_q} + {2'b0, b_q}
         + {2'b0, c_q} + {2'b0, d_q};
    sbc  = {2'b0, b_q} + {2'b0, c_q}
         + {2'b0, d_q};
    sh   = b_q % W_L;
    ex_res = '0;
    ex_ovf = 1'b0;
    ex_dz  = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        ex_res = sum2[WIDTH-1:0];
        ex_ovf = sum2[WIDTH];
      end
      OP_SUB: begin
        ex_res = a_q - b_q;
        ex_ovf = (a_q < b_q);
      end
      OP_ADD4: begin
        ex_res = sum4[WIDTH-1:0];
        ex_ovf = |sum4[WIDTH+1:WIDTH];
      end
      OP_SUB4: begin
        ex_res = a_q - sbc[WIDTH-1:0];
        ex_ovf = (sbc > {2'b0, a_q});
      end
      OP_ROR: begin
        // shift by WIDTH yields zero, so sh==0 is a plain copy
        ex_res = (a_q >> sh)
               | (a_q << (W_L - sh));
      end
      OP_DIV: begin
        ex_res = '1;
        ex_dz  = 1'b1;
      end
      OP_REM: begin
        ex_res = a_q;
        ex_dz  = 1'b1;
      end
      default: begin
        ex_res = '0;
      end
    endcase
  end

  always_comb begin
    ms   = {1'b0, hi_q}
         + (lo_q[0] ? {1'b0, b_q} : '0);
    dt   = {hi_q, lo_q[WIDTH-1]};
    dge  = (dt >= {1'b0, b_q});
    dsub = dt[WIDTH-1:0] - b_q;
    hi_d = '0;
    lo_d = '0;
    if (op_q == OP_MUL) begin
      hi_d = ms[WIDTH:1];
      lo_d = {ms[0], lo_q[WIDTH-1:1]};
    end else begin
      hi_d = dge ? dsub : dt[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], dge};
    end
    it_res = lo_d;
    it_ovf = 1'b0;
    if (op_q == OP_MUL) begin
      it_ovf = |hi_d;
    end else if (op_q == OP_REM) begin
      it_res = hi_d;
    end
  end

  always_comb begin
    go_iter = 1'b0;
    if (bus.opcode == OP_MUL) begin
      go_iter = 1'b1;
    end else if (bus.opcode == OP_DIV ||
                 bus.opcode == OP_REM) begin
      go_iter = (bus.B != '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      div0_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_q  <= bus.opcode;
            a_q   <= bus.A;
            b_q   <= bus.B;
            c_q   <= bus.C;
            d_q   <= bus.D;
            hi_q  <= '0;
            lo_q  <= bus.A;
            cnt_q <= '0;
            state_q <= go_iter ? ITER : EXEC;
          end
        end
        EXEC: begin
          out_q   <= ex_res;
          ovf_q   <= ex_ovf;
          div0_q  <= ex_dz;
          state_q <= HOLD;
        end
        ITER: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            out_q   <= it_res;
            ovf_q   <= it_ovf;
            div0_q  <= 1'b0;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          // result is published one edge after it is latched
          if (!ov_q) begin
            ov_q <= 1'b1;
          end else if (bus.out_ready) begin
            ov_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule
